// File: rtl/misc_issue_ctrl_pkg.sv
// Shared types for the misc-pipe issue controller.
package misc_issue_ctrl_pkg;

    localparam int unsigned NUM_SRC = 2;

    typedef enum logic {
        MISC_IQ_RUN      = 1'b0,
        MISC_IQ_WAIT_CMT = 1'b1
    } misc_iq_state_e;

endpackage

// File: rtl/misc_iq_wake_cmp.sv
// One source tag against every wakeup broadcast port.
// Pure combinational, no state; hit is the OR over all valid matching ports.
module misc_iq_wake_cmp
    import misc_issue_ctrl_pkg::*;
#(
    parameter int PREG_W = 6,
    parameter int WAKE_N = 4
) (
    input  logic [PREG_W-1:0]        tag,
    input  logic [WAKE_N-1:0]        wake_valid,
    input  logic [WAKE_N*PREG_W-1:0] wake_preg,
    output logic                     hit
);

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < WAKE_N; k++) begin
            if (wake_valid[k] && (wake_preg[k*PREG_W +: PREG_W] == tag)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/misc_issue_ctrl.sv
// In-order issue queue for the misc pipe; priv ops serialise until they commit.
// Latency: dispatch to issue is one cycle minimum; wakeups apply the cycle after broadcast.
// Backpressure: disp_ready_o drops on registered full; issue holds the head while issue_ready_i=0.
module misc_issue_ctrl
    import misc_issue_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 128,
    parameter int PREG_W    = 6,
    parameter int ROB_W     = 6,
    parameter int WAKE_N    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        disp_valid_i,
    output logic                        disp_ready_o,
    input  logic [PAYLOAD_W-1:0]        disp_payload_i,
    input  logic                        disp_priv_i,
    input  logic [ROB_W-1:0]            disp_rob_idx_i,
    input  logic [2*PREG_W-1:0]         disp_psrc_i,
    input  logic [1:0]                  disp_src_rdy_i,
    input  logic [WAKE_N-1:0]           wake_valid_i,
    input  logic [WAKE_N*PREG_W-1:0]    wake_preg_i,
    input  logic [ROB_W-1:0]            rob_head_i,
    input  logic                        priv_done_i,
    output logic                        issue_valid_o,
    output logic [PAYLOAD_W-1:0]        issue_payload_o,
    input  logic                        issue_ready_i,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic                           valid;
        logic                           priv;
        logic [ROB_W-1:0]               rob_idx;
        logic [NUM_SRC-1:0][PREG_W-1:0] psrc;
        logic [NUM_SRC-1:0]             rdy;
        logic [PAYLOAD_W-1:0]           payload;
    } misc_iq_entry_t;

    misc_iq_entry_t                   entry_q [DEPTH];
    misc_iq_entry_t                   head_ent;
    misc_iq_entry_t                   disp_ent;
    logic [PTR_W-1:0]                 head_ptr;
    logic [PTR_W-1:0]                 tail_ptr;
    misc_iq_state_e                   state;
    logic                             full;
    logic                             empty;
    logic                             disp_fire;
    logic                             issue_fire;
    logic                             head_priv_ok;
    logic [DEPTH-1:0][NUM_SRC-1:0]    ent_wake_hit;
    logic [NUM_SRC-1:0]               disp_wake_hit;

    // Wake comparators: two per entry plus two for the op being dispatched this cycle.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            misc_iq_wake_cmp #(.PREG_W(PREG_W), .WAKE_N(WAKE_N)) u_cmp (
                .tag        (entry_q[e].psrc[s]),
                .wake_valid (wake_valid_i),
                .wake_preg  (wake_preg_i),
                .hit        (ent_wake_hit[e][s])
            );
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_disp
        misc_iq_wake_cmp #(.PREG_W(PREG_W), .WAKE_N(WAKE_N)) u_cmp (
            .tag        (disp_psrc_i[s*PREG_W +: PREG_W]),
            .wake_valid (wake_valid_i),
            .wake_preg  (wake_preg_i),
            .hit        (disp_wake_hit[s])
        );
    end

    assign full  = (head_ptr[IDX_W-1:0] == tail_ptr[IDX_W-1:0]) &&
                   (head_ptr[IDX_W] != tail_ptr[IDX_W]);
    assign empty = (head_ptr == tail_ptr);

    assign head_ent     = entry_q[head_ptr[IDX_W-1:0]];
    assign head_priv_ok = ~head_ent.priv | (head_ent.rob_idx == rob_head_i);

    assign disp_ready_o    = ~full & ~rst & ~flush_i;
    assign issue_valid_o   = ~empty & head_ent.valid & (state == MISC_IQ_RUN) &
                             (&head_ent.rdy) & head_priv_ok & ~flush_i & ~rst;
    assign issue_payload_o = head_ent.payload;
    assign count_o         = tail_ptr - head_ptr;

    assign disp_fire  = disp_valid_i & disp_ready_o;
    assign issue_fire = issue_valid_o & issue_ready_i;

    always_comb begin
        disp_ent         = '0;
        disp_ent.valid   = 1'b1;
        disp_ent.priv    = disp_priv_i;
        disp_ent.rob_idx = disp_rob_idx_i;
        disp_ent.psrc    = disp_psrc_i;
        disp_ent.payload = disp_payload_i;
        for (int s = 0; s < NUM_SRC; s++) begin
            disp_ent.rdy[s] = disp_src_rdy_i[s] |
                              (disp_psrc_i[s*PREG_W +: PREG_W] == '0) |
                              disp_wake_hit[s];
        end
    end

    // Pointers and serialisation state; flush shares the reset path.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            state    <= MISC_IQ_RUN;
        end else begin
            if (disp_fire) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (issue_fire) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case (state)
                MISC_IQ_RUN: begin
                    if (issue_fire && head_ent.priv) begin
                        state <= MISC_IQ_WAIT_CMT;
                    end
                end
                MISC_IQ_WAIT_CMT: begin
                    if (priv_done_i) begin
                        state <= MISC_IQ_RUN;
                    end
                end
                default: state <= MISC_IQ_RUN;
            endcase
        end
    end

    // Pop and push never target the same slot: that needs both full and empty at once.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (rst || flush_i) begin
                entry_q[e].valid <= 1'b0;
            end else begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (entry_q[e].valid && ent_wake_hit[e][s]) begin
                        entry_q[e].rdy[s] <= 1'b1;
                    end
                end
                if (issue_fire && (head_ptr[IDX_W-1:0] == IDX_W'(e))) begin
                    entry_q[e].valid <= 1'b0;
                end
                if (disp_fire && (tail_ptr[IDX_W-1:0] == IDX_W'(e))) begin
                    entry_q[e] <= disp_ent;
                end
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_o <= ($clog2(DEPTH)+1)'(DEPTH));
    a_no_issue_in_wait: assert property (@(posedge clk) disable iff (rst)
        (state == MISC_IQ_WAIT_CMT) |-> !issue_valid_o);

endmodule
